instr_assembler: RTL and testbench
==================================

INSTR_ASSEMBLER -- requirements
Module: instr_assembler

Interface
REQ-001 SHALL have parameter BYTE_W, 8, width of incoming file bytes.
REQ-002 SHALL have parameter INSTR_W, 16, assembled instruction width (2*BYTE_W).
REQ-003 SHALL have parameter DEPTH, 64, instruction-memory words; ADDR_W = clog2(DEPTH).
REQ-004 SHALL have port clock  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-006 SHALL have port start  input  1  one-cycle pulse that begins a program load.
REQ-007 SHALL have port byte_in  input  BYTE_W  byte from the file-reader stage.
REQ-008 SHALL have port byte_valid  input  1  byte_in holds a valid byte this cycle.
REQ-009 SHALL have port byte_ready  output  1  block accepts byte_in this cycle.
REQ-010 SHALL have port instr_out  output  INSTR_W  assembled instruction to instruction memory.
REQ-011 SHALL have port instr_addr  output  ADDR_W  write address for instr_out.
REQ-012 SHALL have port instr_we  output  1  one-cycle write strobe for instr_out/instr_addr.
REQ-013 SHALL have port load_done  output  1  level; load finished, held until next start or reset.
REQ-014 SHALL have port load_full  output  1  level; load ended because DEPTH words were written.
REQ-015 SHALL have port instr_count  output  ADDR_W+1  number of words written in current/last load.

Function
REQ-016 SHALL implement FSM states IDLE, HI, LO, WRITE, DONE.
REQ-017 IDLE -> HI on start; start clears instr_count, load_done, load_full.
REQ-018 Byte transfer SHALL occur only when byte_valid && byte_ready on a rising edge.
REQ-019 byte_ready SHALL be 1 exactly in HI and LO, 0 in IDLE, WRITE, DONE.
REQ-020 HI: transfer captures byte_in as instr_out[15:8] (big-endian), -> LO; no transfer stays HI.
REQ-021 LO: transfer captures byte_in as instr_out[7:0], -> WRITE; no transfer stays LO.
REQ-022 WRITE: instr_we = 1 for exactly this one cycle, instr_addr = instr_count[ADDR_W-1:0]; then instr_count increments.
REQ-023 Latency: instr_we asserted in the cycle immediately after the low-byte transfer.
REQ-024 Terminator: assembled word 16'hFFFF SHALL NOT be written (instr_we stays 0), -> DONE, instr_count unchanged.
REQ-025 After a non-terminator write, if instr_count reaches DEPTH -> DONE with load_full = 1; else -> HI.
REQ-026 DONE: load_done = 1; remains until start (-> HI, flags cleared) or reset.
REQ-027 start SHALL be ignored in HI, LO, WRITE (no restart mid-load).
REQ-028 instr_out and instr_addr SHALL hold their last values when instr_we = 0.
REQ-029 byte_valid with byte_ready = 0 SHALL have no effect; upstream must hold byte until accepted.
REQ-030 instr_count SHALL never exceed DEPTH; address wrap is impossible by REQ-025.

Reset
REQ-031 When reset = 0 at a rising edge: state = IDLE, instr_out = 0, instr_addr = 0, instr_we = 0, byte_ready = 0, load_done = 0, load_full = 0, instr_count = 0.
REQ-032 Reset SHALL override start and any in-progress transfer, including mid-word (partial high byte discarded).

Structure
REQ-033 FSM state encoding, terminator constant 16'hFFFF and default DEPTH SHALL live in shared package ti170_pkg.
REQ-034 Single flat module; no sub-modules required.

Verification
REQ-035 start, bytes 12,34,56,78,FF,FF with valid every cycle -> writes 1234@0, 5678@1; load_done=1, load_full=0, instr_count=2.
REQ-036 Valid toggling 1/0 with bytes AB,CD -> single write ABCD@0 one cycle after CD accepted; byte_ready never 1 in WRITE.
REQ-037 DEPTH=4, eight non-FF bytes 01..08 -> writes 0102,0304,0506,0708 @0..3; load_full=1, byte_ready=0 afterwards.
REQ-038 reset=0 after byte 12 accepted (in LO) -> all outputs zero next cycle; new start, bytes 9A,BC -> write 9ABC@0.
REQ-039 start pulsed during LO -> ignored, load continues; start in DONE -> flags and instr_count cleared, new load from address 0.
REQ-040 Bytes FF,00 -> written as FF00 (not terminator); only full FFFF word ends the load.

Source files
------------

// File: rtl/ti170_pkg.sv
// Shared constants for the instruction assembler: FSM encoding,
// end-of-program marker and default memory depth.
package ti170_pkg;

    localparam int DEFAULT_DEPTH = 64;

    // A full all-ones word marks the end of the program image.
    localparam logic [15:0] TERMINATOR = 16'hFFFF;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_HI    = 3'd1;
    localparam logic [2:0] ST_LO    = 3'd2;
    localparam logic [2:0] ST_WRITE = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

endpackage

// File: rtl/instr_assembler.sv
// Packs a big-endian byte stream into instruction words and writes them
// to instruction memory until a terminator word or a full memory.
//
// state | meaning
// IDLE  | waiting for start
// HI    | accepting high byte
// LO    | accepting low byte
// WRITE | presenting assembled word (strobe unless terminator)
// DONE  | load finished, flags held until next start
module instr_assembler
    import ti170_pkg::*;
#(
    parameter int BYTE_W  = 8,
    parameter int INSTR_W = 16,
    parameter int DEPTH   = DEFAULT_DEPTH,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic [BYTE_W-1:0]   byte_in,
    input  logic                byte_valid,
    output logic                byte_ready,
    output logic [INSTR_W-1:0]  instr_out,
    output logic [ADDR_W-1:0]   instr_addr,
    output logic                instr_we,
    output logic                load_done,
    output logic                load_full,
    output logic [ADDR_W:0]     instr_count
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    logic [2:0]         state_q, state_d;
    logic [BYTE_W-1:0]  hi_q, hi_d;
    logic               term_q, term_d;
    logic [INSTR_W-1:0] instr_out_q, instr_out_d;
    logic [ADDR_W-1:0]  instr_addr_q, instr_addr_d;
    logic               we_q, we_d;
    logic [ADDR_W:0]    count_q, count_d;
    logic               done_q, done_d;
    logic               full_q, full_d;

    logic               xfer;
    logic [INSTR_W-1:0] word;

    assign byte_ready = (state_q == ST_HI) || (state_q == ST_LO);
    assign xfer       = byte_valid && byte_ready;
    assign word       = {hi_q, byte_in};

    always_comb begin
        state_d      = state_q;
        hi_d         = hi_q;
        term_d       = term_q;
        instr_out_d  = instr_out_q;
        instr_addr_d = instr_addr_q;
        we_d         = 1'b0;
        count_d      = count_q;
        done_d       = done_q;
        full_d       = full_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_HI;
                    count_d = '0;
                    done_d  = 1'b0;
                    full_d  = 1'b0;
                end
            end
            ST_HI: begin
                if (xfer) begin
                    hi_d    = byte_in;
                    state_d = ST_LO;
                end
            end
            ST_LO: begin
                if (xfer) begin
                    state_d = ST_WRITE;
                    term_d  = (word == TERMINATOR);
                    // Output registers only move when a real write is issued.
                    if (word != TERMINATOR) begin
                        instr_out_d  = word;
                        instr_addr_d = count_q[ADDR_W-1:0];
                        we_d         = 1'b1;
                    end
                end
            end
            ST_WRITE: begin
                if (term_q) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    count_d = count_q + 1'b1;
                    if (count_d == DEPTH_C) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        full_d  = 1'b1;
                    end else begin
                        state_d = ST_HI;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            hi_q         <= '0;
            term_q       <= 1'b0;
            instr_out_q  <= '0;
            instr_addr_q <= '0;
            we_q         <= 1'b0;
            count_q      <= '0;
            done_q       <= 1'b0;
            full_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            hi_q         <= hi_d;
            term_q       <= term_d;
            instr_out_q  <= instr_out_d;
            instr_addr_q <= instr_addr_d;
            we_q         <= we_d;
            count_q      <= count_d;
            done_q       <= done_d;
            full_q       <= full_d;
        end
    end

    assign instr_out   = instr_out_q;
    assign instr_addr  = instr_addr_q;
    assign instr_we    = we_q;
    assign load_done   = done_q;
    assign load_full   = full_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_instr_assembler.sv
// Directed bench for instr_assembler: a default-depth instance and a
// DEPTH=4 instance for the memory-full case.
`timescale 1ns/1ps
module tb_instr_assembler;

    logic        clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset, start, byte_valid;
    logic [7:0]  byte_in;
    logic        byte_ready, instr_we, load_done, load_full;
    logic [15:0] instr_out;
    logic [5:0]  instr_addr;
    logic [6:0]  instr_count;

    logic        start4, byte_valid4;
    logic [7:0]  byte_in4;
    logic        byte_ready4, instr_we4, load_done4, load_full4;
    logic [15:0] instr_out4;
    logic [1:0]  instr_addr4;
    logic [2:0]  instr_count4;

    instr_assembler dut (
        .clock(clock), .reset(reset), .start(start), .byte_in(byte_in),
        .byte_valid(byte_valid), .byte_ready(byte_ready), .instr_out(instr_out),
        .instr_addr(instr_addr), .instr_we(instr_we), .load_done(load_done),
        .load_full(load_full), .instr_count(instr_count)
    );

    instr_assembler #(.DEPTH(4)) dut4 (
        .clock(clock), .reset(reset), .start(start4), .byte_in(byte_in4),
        .byte_valid(byte_valid4), .byte_ready(byte_ready4), .instr_out(instr_out4),
        .instr_addr(instr_addr4), .instr_we(instr_we4), .load_done(load_done4),
        .load_full(load_full4), .instr_count(instr_count4)
    );

    int vectors = 0;
    int miscompares = 0;

    logic [15:0] wd[$];
    logic [5:0]  wa[$];
    logic [15:0] wd4[$];
    logic [1:0]  wa4[$];

    always @(posedge clock) begin
        if (instr_we === 1'b1) begin
            wd.push_back(instr_out);
            wa.push_back(instr_addr);
        end
        if (instr_we4 === 1'b1) begin
            wd4.push_back(instr_out4);
            wa4.push_back(instr_addr4);
        end
    end

    task automatic send(input bit sel, input logic [7:0] b);
        bit ok = 1'b0;
        if (sel) begin byte_in4 = b; byte_valid4 = 1'b1; end
        else     begin byte_in  = b; byte_valid  = 1'b1; end
        for (int n = 0; n < 50 && !ok; n++) begin
            if ((sel ? byte_ready4 : byte_ready) === 1'b1) ok = 1'b1;
            @(negedge clock);
        end
        if (!ok) begin
            vectors++; miscompares++;
            $display("FAIL send_timeout byte=%h: byte_ready never seen, required 1", b);
        end
    endtask

    task automatic idle();
        byte_valid  = 1'b0;
        byte_valid4 = 1'b0;
    endtask

    task automatic pulse_start(input bit sel);
        if (sel) start4 = 1'b1; else start = 1'b1;
        @(negedge clock);
        start = 1'b0; start4 = 1'b0;
    endtask

    task automatic wait_done(input bit sel);
        bit ok = 1'b0;
        for (int n = 0; n < 20 && !ok; n++) begin
            if ((sel ? load_done4 : load_done) === 1'b1) ok = 1'b1;
            else @(negedge clock);
        end
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL wait_done: load_done=0 after 20 cycles, required 1");
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; start4 = 1'b0;
        byte_valid = 1'b0; byte_valid4 = 1'b0; byte_in = '0; byte_in4 = '0;
        repeat (3) @(negedge clock);
        vectors++;
        if ({instr_out, instr_addr, instr_we, byte_ready, load_done, load_full, instr_count} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: out=%h addr=%0d we=%b rdy=%b done=%b full=%b cnt=%0d, required all 0",
                     instr_out, instr_addr, instr_we, byte_ready, load_done, load_full, instr_count);
        end
        vectors++;
        if ({instr_out4, instr_addr4, instr_we4, byte_ready4, load_done4, load_full4, instr_count4} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs4: out=%h cnt=%0d rdy=%b, required all 0",
                     instr_out4, instr_count4, byte_ready4);
        end
        reset = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_basic();
        int base = wd.size();
        pulse_start(0);
        send(0, 8'h12); send(0, 8'h34); send(0, 8'h56); send(0, 8'h78);
        send(0, 8'hFF); send(0, 8'hFF);
        idle();
        wait_done(0);
        vectors++;
        if (wd.size() != base + 2) begin
            miscompares++;
            $display("FAIL basic_write_count: got %0d writes, required 2", wd.size() - base);
        end else begin
            vectors++;
            if (wd[base] !== 16'h1234 || wa[base] !== 6'd0) begin
                miscompares++;
                $display("FAIL basic_w0: got %h@%0d, required 1234@0", wd[base], wa[base]);
            end
            vectors++;
            if (wd[base+1] !== 16'h5678 || wa[base+1] !== 6'd1) begin
                miscompares++;
                $display("FAIL basic_w1: got %h@%0d, required 5678@1", wd[base+1], wa[base+1]);
            end
        end
        vectors++;
        if (load_full !== 1'b0 || instr_count !== 7'd2 || byte_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_flags: full=%b cnt=%0d rdy=%b, required full=0 cnt=2 rdy=0",
                     load_full, instr_count, byte_ready);
        end
        vectors++;
        if (instr_out !== 16'h5678 || instr_addr !== 6'd1) begin
            miscompares++;
            $display("FAIL basic_hold: got %h@%0d, required 5678@1", instr_out, instr_addr);
        end
    endtask

    task automatic test_valid_toggle();
        int base = wd.size();
        pulse_start(0);
        send(0, 8'hAB);
        idle();
        @(negedge clock);
        send(0, 8'hCD);
        idle();
        vectors++;
        if (instr_we !== 1'b1 || byte_ready !== 1'b0 || instr_out !== 16'hABCD || instr_addr !== 6'd0) begin
            miscompares++;
            $display("FAIL toggle_write: we=%b rdy=%b out=%h addr=%0d, required we=1 rdy=0 ABCD@0",
                     instr_we, byte_ready, instr_out, instr_addr);
        end
        @(negedge clock);
        vectors++;
        if (instr_we !== 1'b0 || instr_count !== 7'd1 || byte_ready !== 1'b1 || instr_out !== 16'hABCD) begin
            miscompares++;
            $display("FAIL toggle_after: we=%b cnt=%0d rdy=%b out=%h, required we=0 cnt=1 rdy=1 out=ABCD",
                     instr_we, instr_count, byte_ready, instr_out);
        end
        send(0, 8'hFF); send(0, 8'hFF);
        idle();
        wait_done(0);
        vectors++;
        if (wd.size() != base + 1 || instr_count !== 7'd1) begin
            miscompares++;
            $display("FAIL toggle_total: writes=%0d cnt=%0d, required writes=1 cnt=1",
                     wd.size() - base, instr_count);
        end
    endtask

    task automatic test_reset_mid_word();
        pulse_start(0);
        send(0, 8'h12);
        idle();
        reset = 1'b0;
        @(negedge clock);
        vectors++;
        if ({instr_out, instr_addr, instr_we, byte_ready, load_done, load_full, instr_count} !== '0) begin
            miscompares++;
            $display("FAIL midreset_outputs: out=%h addr=%0d we=%b rdy=%b done=%b full=%b cnt=%0d, required all 0",
                     instr_out, instr_addr, instr_we, byte_ready, load_done, load_full, instr_count);
        end
        reset = 1'b1;
        @(negedge clock);
        pulse_start(0);
        send(0, 8'h9A); send(0, 8'hBC);
        idle();
        vectors++;
        if (instr_we !== 1'b1 || instr_out !== 16'h9ABC || instr_addr !== 6'd0) begin
            miscompares++;
            $display("FAIL midreset_reload: we=%b out=%h addr=%0d, required we=1 9ABC@0",
                     instr_we, instr_out, instr_addr);
        end
        send(0, 8'hFF); send(0, 8'hFF);
        idle();
        wait_done(0);
    endtask

    task automatic test_start_mid_load();
        pulse_start(0);
        send(0, 8'h12);
        idle();
        pulse_start(0);
        vectors++;
        if (byte_ready !== 1'b1 || instr_count !== 7'd0 || load_done !== 1'b0) begin
            miscompares++;
            $display("FAIL start_in_lo: rdy=%b cnt=%0d done=%b, required rdy=1 cnt=0 done=0",
                     byte_ready, instr_count, load_done);
        end
        send(0, 8'h34);
        idle();
        vectors++;
        if (instr_we !== 1'b1 || instr_out !== 16'h1234 || instr_addr !== 6'd0) begin
            miscompares++;
            $display("FAIL start_in_lo_word: we=%b out=%h addr=%0d, required we=1 1234@0",
                     instr_we, instr_out, instr_addr);
        end
        send(0, 8'hFF); send(0, 8'hFF);
        idle();
        wait_done(0);
        vectors++;
        if (instr_count !== 7'd1) begin
            miscompares++;
            $display("FAIL start_in_lo_count: cnt=%0d, required 1", instr_count);
        end
        pulse_start(0);
        vectors++;
        if (load_done !== 1'b0 || instr_count !== 7'd0 || byte_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL restart_from_done: done=%b cnt=%0d rdy=%b, required done=0 cnt=0 rdy=1",
                     load_done, instr_count, byte_ready);
        end
        send(0, 8'h11); send(0, 8'h22);
        idle();
        vectors++;
        if (instr_we !== 1'b1 || instr_out !== 16'h1122 || instr_addr !== 6'd0) begin
            miscompares++;
            $display("FAIL restart_word: we=%b out=%h addr=%0d, required we=1 1122@0",
                     instr_we, instr_out, instr_addr);
        end
        send(0, 8'hFF); send(0, 8'hFF);
        idle();
        wait_done(0);
    endtask

    task automatic test_ff00();
        pulse_start(0);
        send(0, 8'hFF); send(0, 8'h00);
        idle();
        vectors++;
        if (instr_we !== 1'b1 || instr_out !== 16'hFF00 || instr_addr !== 6'd0) begin
            miscompares++;
            $display("FAIL ff00_write: we=%b out=%h addr=%0d, required we=1 FF00@0",
                     instr_we, instr_out, instr_addr);
        end
        send(0, 8'hFF); send(0, 8'hFF);
        idle();
        wait_done(0);
        vectors++;
        if (instr_count !== 7'd1 || load_full !== 1'b0) begin
            miscompares++;
            $display("FAIL ff00_count: cnt=%0d full=%b, required cnt=1 full=0", instr_count, load_full);
        end
    endtask

    task automatic test_full();
        logic [15:0] exp_d;
        int base = wd4.size();
        pulse_start(1);
        for (int i = 1; i <= 8; i++) send(1, 8'(i));
        idle();
        wait_done(1);
        vectors++;
        if (wd4.size() != base + 4) begin
            miscompares++;
            $display("FAIL full_write_count: got %0d writes, required 4", wd4.size() - base);
        end else begin
            for (int k = 0; k < 4; k++) begin
                exp_d = {8'(2*k+1), 8'(2*k+2)};
                vectors++;
                if (wd4[base+k] !== exp_d || wa4[base+k] !== 2'(k)) begin
                    miscompares++;
                    $display("FAIL full_w%0d: got %h@%0d, required %h@%0d",
                             k, wd4[base+k], wa4[base+k], exp_d, k);
                end
            end
        end
        vectors++;
        if (load_full4 !== 1'b1 || byte_ready4 !== 1'b0 || instr_count4 !== 3'd4) begin
            miscompares++;
            $display("FAIL full_flags: full=%b rdy=%b cnt=%0d, required full=1 rdy=0 cnt=4",
                     load_full4, byte_ready4, instr_count4);
        end
        byte_in4 = 8'h55; byte_valid4 = 1'b1;
        repeat (3) @(negedge clock);
        idle();
        vectors++;
        if (byte_ready4 !== 1'b0 || instr_count4 !== 3'd4 || wd4.size() != base + 4) begin
            miscompares++;
            $display("FAIL full_stays: rdy=%b cnt=%0d writes=%0d, required rdy=0 cnt=4 writes=4",
                     byte_ready4, instr_count4, wd4.size() - base);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_valid_toggle();
        test_reset_mid_word();
        test_start_mid_load();
        test_ff00();
        test_full();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
